// File: rtl/matmul_scheduler_pkg.sv
// Shared definitions for the matrix-multiply scheduler.
//   state_t   : scheduler FSM states
//   calc_accw : result width, 2*Nbits + clog2(Ndata)
//   idx_width : width of a row/column/k index, never below 1
package matmul_scheduler_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      EMIT  = 2'd2,
      DONE  = 2'd3
   } state_t;

   function automatic int calc_accw(input int ndata, input int nbits);
      return 2 * nbits + $clog2(ndata);
   endfunction

   function automatic int idx_width(input int ndata);
      return ($clog2(ndata) < 1) ? 1 : $clog2(ndata);
   endfunction

endpackage

// File: rtl/sched_mac.sv
// Multiply-accumulate datapath for one result element.
//   clk, reset : clock and synchronous active-low reset
//   clr        : zero the accumulator (wins over en)
//   en         : add a*b to the accumulator this cycle
//   a, b       : unsigned operands
//   acc        : running sum, full ACCW width
module sched_mac
   import matmul_scheduler_pkg::*;
#(
   parameter int Nbits = 8,
   parameter int ACCW  = calc_accw(4, 8)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   input  logic [Nbits-1:0] a,
   input  logic [Nbits-1:0] b,
   output logic [ACCW-1:0]  acc
);

   logic [ACCW-1:0] acc_reg;
   logic [ACCW-1:0] prod;

   // Widen before multiplying so the product is never truncated.
   assign prod = ACCW'(a) * ACCW'(b);

   always_ff @(posedge clk) begin
      if (!reset) begin
         acc_reg <= '0;
      end else if (clr) begin
         acc_reg <= '0;
      end else if (en) begin
         acc_reg <= acc_reg + prod;
      end
   end

   assign acc = acc_reg;

endmodule

// File: rtl/matmul_scheduler.sv
// Sequential N x N matrix-multiply scheduler. Latches A and B on start, then
// for each C(i,j) in row-major order spends N cycles accumulating
// A(i,k)*B(k,j) and presents the sum on a valid/ready output.
//   clk, reset     : clock and synchronous active-low reset
//   start, abort   : begin a product (IDLE only) / cancel the current one
//   A, B           : flat operand matrices, element (r,c) at [(r*N+c)*Nbits +: Nbits]
//   c_data/row/col : result element and its indices, qualified by c_valid
//   c_ready        : consumer accepts the element on c_valid & c_ready
//   busy, done     : not IDLE / one-cycle pulse after the last element
module matmul_scheduler
   import matmul_scheduler_pkg::*;
#(
   parameter  int Ndata = 4,
   parameter  int Nbits = 8,
   localparam int ACCW  = calc_accw(Ndata, Nbits),
   localparam int IW    = idx_width(Ndata),
   localparam int MW    = Nbits * Ndata * Ndata
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            abort,
   input  logic [MW-1:0]   A,
   input  logic [MW-1:0]   B,
   output logic [ACCW-1:0] c_data,
   output logic [IW-1:0]   c_row,
   output logic [IW-1:0]   c_col,
   output logic            c_valid,
   input  logic            c_ready,
   output logic            busy,
   output logic            done
);

   localparam logic [IW-1:0] LAST_IDX = IW'(Ndata - 1);

   state_t state_reg, state_next;
   logic [MW-1:0] a_reg, b_reg;
   logic [IW-1:0] i_reg, j_reg, k_reg;

   logic latch, mac_clr, mac_en, advance;
   logic last_k, last_elem;
   logic [Nbits-1:0] a_op, b_op;

   assign last_k    = (k_reg == LAST_IDX);
   assign last_elem = (i_reg == LAST_IDX) && (j_reg == LAST_IDX);

   // Operand selection straight from the latched copies.
   assign a_op = a_reg[(int'(i_reg) * Ndata + int'(k_reg)) * Nbits +: Nbits];
   assign b_op = b_reg[(int'(k_reg) * Ndata + int'(j_reg)) * Nbits +: Nbits];

   always_comb begin
      state_next = state_reg;
      latch      = 1'b0;
      mac_clr    = 1'b0;
      mac_en     = 1'b0;
      advance    = 1'b0;
      case (state_reg)
         IDLE: begin
            // abort in IDLE also swallows a coincident start
            if (start && !abort) begin
               latch      = 1'b1;
               mac_clr    = 1'b1;
               state_next = ACCUM;
            end
         end
         ACCUM: begin
            if (abort) begin
               state_next = IDLE;
            end else begin
               mac_en = 1'b1;
               if (last_k) state_next = EMIT;
            end
         end
         EMIT: begin
            if (abort) begin
               state_next = IDLE;
            end else if (c_ready) begin
               if (last_elem) begin
                  state_next = DONE;
               end else begin
                  advance    = 1'b1;
                  mac_clr    = 1'b1;
                  state_next = ACCUM;
               end
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg <= IDLE;
         a_reg     <= '0;
         b_reg     <= '0;
         i_reg     <= '0;
         j_reg     <= '0;
         k_reg     <= '0;
      end else begin
         state_reg <= state_next;
         if (latch) begin
            a_reg <= A;
            b_reg <= B;
            i_reg <= '0;
            j_reg <= '0;
            k_reg <= '0;
         end
         if (mac_en) begin
            k_reg <= last_k ? '0 : k_reg + IW'(1);
         end
         if (advance) begin
            if (j_reg == LAST_IDX) begin
               j_reg <= '0;
               i_reg <= i_reg + IW'(1);
            end else begin
               j_reg <= j_reg + IW'(1);
            end
         end
      end
   end

   sched_mac #(
      .Nbits (Nbits),
      .ACCW  (ACCW)
   ) u_mac (
      .clk   (clk),
      .reset (reset),
      .clr   (mac_clr),
      .en    (mac_en),
      .a     (a_op),
      .b     (b_op),
      .acc   (c_data)
   );

   assign c_row   = i_reg;
   assign c_col   = j_reg;
   assign c_valid = (state_reg == EMIT);
   assign busy    = (state_reg != IDLE);
   assign done    = (state_reg == DONE);

endmodule

// File: tb/tb_matmul_scheduler.sv
module tb_matmul_scheduler;

   localparam int N    = 4;
   localparam int W    = 8;
   localparam int ACCW = 2 * W + 2;
   localparam int IW   = 2;
   localparam int NE   = N * N;
   localparam int MW   = W * N * N;

   typedef logic [MW-1:0] mat_t;

   logic            clk = 1'b0;
   logic            reset, start, abort, c_ready;
   mat_t            A, B;
   logic [ACCW-1:0] c_data;
   logic [IW-1:0]   c_row, c_col;
   logic            c_valid, busy, done;

   int checks = 0;
   int errors = 0;

   // results captured by collect()
   logic [ACCW-1:0] got_data [NE];
   int got_row [NE];
   int got_col [NE];
   int hs_cycle [NE];
   int n_got, done_cycle, done_count, stall_total, stall_changes;
   logic busy_after_abort, valid_after_abort;

   matmul_scheduler #(.Ndata(N), .Nbits(W)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .abort   (abort),
      .A       (A),
      .B       (B),
      .c_data  (c_data),
      .c_row   (c_row),
      .c_col   (c_col),
      .c_valid (c_valid),
      .c_ready (c_ready),
      .busy    (busy),
      .done    (done)
   );

   always #5 clk = ~clk;

   // Reference: C(i,j) = sum_k A(i,k)*B(k,j), exact integer arithmetic.
   function automatic logic [ACCW-1:0] ref_c(input mat_t a, input mat_t b, input int i, input int j);
      longint s = 0;
      for (int k = 0; k < N; k++)
         s += longint'(a[(i*N+k)*W +: W]) * longint'(b[(k*N+j)*W +: W]);
      return ACCW'(s);
   endfunction

   function automatic mat_t rand_mat();
      mat_t m;
      for (int e = 0; e < NE; e++) m[e*W +: W] = W'($urandom_range(0, 255));
      return m;
   endfunction

   // Issue start at a negedge; returns at the negedge after the sampling edge (cycle 0).
   task automatic kick(input mat_t a, input mat_t b);
      A = a; B = b; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Drive c_ready/abort/start for cycles 1..max_cycles and record what the DUT emits.
   // ready_mode: 0 always ready, 1 random, 2 stall 10 cycles at element (1,2).
   task automatic collect(input int ready_mode, input int abort_at, input int glitch_at, input int max_cycles);
      logic [ACCW-1:0] sd;
      int sr, sc;
      n_got = 0; done_cycle = -1; done_count = 0;
      stall_total = 0; stall_changes = 0;
      busy_after_abort = 1'b1; valid_after_abort = 1'b1;
      sd = '0; sr = 0; sc = 0;
      for (int t = 1; t <= max_cycles; t++) begin
         abort = (t == abort_at);
         start = (t == glitch_at);
         if (t == glitch_at) A = ~A;
         c_ready = 1'b1;
         if (ready_mode == 1) c_ready = 1'($urandom_range(0, 1));
         if (ready_mode == 2 && c_valid && c_row == 2'd1 && c_col == 2'd2 && stall_total < 10) begin
            if (stall_total == 0) begin
               sd = c_data; sr = int'(c_row); sc = int'(c_col);
            end else if (c_data !== sd || int'(c_row) != sr || int'(c_col) != sc || c_valid !== 1'b1) begin
               stall_changes++;
            end
            c_ready = 1'b0;
            stall_total++;
         end
         if (t == abort_at + 1) begin
            busy_after_abort = busy; valid_after_abort = c_valid;
         end
         if (c_valid && c_ready && !abort && n_got < NE) begin
            got_data[n_got] = c_data;
            got_row[n_got]  = int'(c_row);
            got_col[n_got]  = int'(c_col);
            hs_cycle[n_got] = t;
            $display("t=%0d elem %0d C(%0d,%0d)=%0d", t, n_got, c_row, c_col, c_data);
            n_got++;
         end
         if (done) begin
            done_count++;
            if (done_cycle < 0) done_cycle = t;
         end
         @(negedge clk);
         if (done_cycle >= 0 && abort_at < 0) break;
      end
      abort = 1'b0; start = 1'b0; c_ready = 1'b0;
   endtask

   // Compare the recorded stream with the model in row-major order.
   task automatic check_stream(input string tag, input mat_t a, input mat_t b, input int want_timing);
      checks++;
      if (n_got !== NE) begin
         errors++; $display("FAIL %s count: got %0d want %0d", tag, n_got, NE);
      end
      for (int e = 0; e < n_got; e++) begin
         checks++;
         if (got_row[e] != e / N || got_col[e] != e % N || got_data[e] !== ref_c(a, b, e / N, e % N)) begin
            errors++;
            $display("FAIL %s elem %0d: got (%0d,%0d)=%0d want (%0d,%0d)=%0d", tag, e,
                     got_row[e], got_col[e], got_data[e], e / N, e % N, ref_c(a, b, e / N, e % N));
         end
         if (want_timing != 0) begin
            checks++;
            if (hs_cycle[e] != (e + 1) * (N + 1)) begin
               errors++; $display("FAIL %s hs_cycle %0d: got %0d want %0d", tag, e, hs_cycle[e], (e + 1) * (N + 1));
            end
         end
      end
      checks++;
      if (done_count != 1) begin
         errors++; $display("FAIL %s done_pulses: got %0d want 1", tag, done_count);
      end
      if (want_timing != 0) begin
         checks++;
         if (done_cycle != NE * (N + 1) + 1) begin
            errors++; $display("FAIL %s done_cycle: got %0d want %0d", tag, done_cycle, NE * (N + 1) + 1);
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; start = 1'b1; abort = 1'b0; c_ready = 1'b1;
      A = rand_mat(); B = rand_mat();
      repeat (3) @(negedge clk);
      checks++;
      if ({busy, done, c_valid} !== 3'b000 || c_data !== '0 || c_row !== '0 || c_col !== '0) begin
         errors++;
         $display("FAIL reset_state: busy=%b done=%b valid=%b data=%0d row=%0d col=%0d want all 0",
                  busy, done, c_valid, c_data, c_row, c_col);
      end
      reset = 1'b1; start = 1'b0; c_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++; $display("FAIL reset_start_priority: busy=%b want 0", busy);
      end
      $display("reset checked");
   endtask

   task automatic test_idle_abort();
      A = rand_mat(); B = rand_mat();
      abort = 1'b1; start = 1'b1;
      @(negedge clk);
      abort = 1'b0; start = 1'b0;
      checks++;
      if (busy !== 1'b0) begin
         errors++; $display("FAIL idle_abort: busy=%b want 0", busy);
      end
      $display("idle abort+start checked");
   endtask

   task automatic test_identity();
      mat_t a, b;
      a = '0;
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++) begin
            a[(r*N+c)*W +: W] = (r == c) ? W'(1) : W'(0);
            b[(r*N+c)*W +: W] = W'(4 * r + c);
         end
      kick(a, b);
      collect(0, -1, -1, 200);
      check_stream("identity", a, b, 1);
   endtask

   task automatic test_all_ff();
      mat_t a;
      a = '1;
      kick(a, a);
      collect(0, -1, -1, 200);
      check_stream("all_ff", a, a, 1);
      checks++;
      if (got_data[0] !== 18'd260100) begin
         errors++; $display("FAIL all_ff_value: got %0d want 260100", got_data[0]);
      end
   endtask

   task automatic test_backpressure();
      mat_t a, b;
      a = rand_mat(); b = rand_mat();
      kick(a, b);
      collect(2, -1, -1, 300);
      checks++;
      if (stall_total != 10 || stall_changes != 0) begin
         errors++; $display("FAIL stall: cycles=%0d changes=%0d want 10 and 0", stall_total, stall_changes);
      end
      check_stream("backpressure", a, b, 0);
   endtask

   task automatic test_abort();
      mat_t a, b;
      a = rand_mat(); b = rand_mat();
      kick(a, b);
      collect(0, 30, -1, 45);
      checks++;
      if (busy_after_abort !== 1'b0 || valid_after_abort !== 1'b0) begin
         errors++; $display("FAIL abort_idle: busy=%b valid=%b want 0 0", busy_after_abort, valid_after_abort);
      end
      checks++;
      if (done_count != 0 || n_got != 5) begin
         errors++; $display("FAIL abort_progress: done=%0d elems=%0d want 0 5", done_count, n_got);
      end
      a = rand_mat(); b = rand_mat();
      kick(a, b);
      collect(0, -1, -1, 200);
      check_stream("after_abort", a, b, 1);
   endtask

   task automatic test_reset_mid();
      mat_t a, b;
      a = rand_mat(); b = rand_mat();
      kick(a, b);
      c_ready = 1'b0;
      repeat (6) @(negedge clk);
      checks++;
      if (c_valid !== 1'b1) begin
         errors++; $display("FAIL reset_mid_emit: valid=%b want 1", c_valid);
      end
      reset = 1'b0; abort = 1'b1; start = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({busy, done, c_valid} !== 3'b000 || c_data !== '0 || c_row !== '0 || c_col !== '0) begin
         errors++;
         $display("FAIL reset_mid_outputs: busy=%b done=%b valid=%b data=%0d row=%0d col=%0d want all 0",
                  busy, done, c_valid, c_data, c_row, c_col);
      end
      reset = 1'b1; abort = 1'b0; start = 1'b0;
      @(negedge clk);
      a = rand_mat(); b = rand_mat();
      kick(a, b);
      collect(0, -1, -1, 200);
      check_stream("after_reset", a, b, 1);
   endtask

   task automatic test_busy_start();
      mat_t a, b;
      a = rand_mat(); b = rand_mat();
      kick(a, b);
      collect(0, -1, 8, 200);
      check_stream("busy_start", a, b, 1);
   endtask

   task automatic test_random();
      mat_t a, b;
      for (int r = 0; r < 3; r++) begin
         a = rand_mat(); b = rand_mat();
         kick(a, b);
         collect(1, -1, -1, 600);
         check_stream("random", a, b, 0);
      end
   endtask

   initial begin
      reset = 1'b0; start = 1'b0; abort = 1'b0; c_ready = 1'b0;
      A = '0; B = '0;
      @(negedge clk);
      test_reset();
      test_idle_abort();
      test_identity();
      test_all_ff();
      test_backpressure();
      test_abort();
      test_reset_mid();
      test_busy_start();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
